// File: rtl/menu_pkg.sv
// Shared types and constants for the menu button bank: FSM states, colours and marker geometry.
package menu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NAV   = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } menu_state_t;

  localparam logic [11:0] DESELECTED_COLOR = 12'hF50;
  localparam logic [11:0] SELECTED_COLOR   = 12'hFF0;
  localparam logic [11:0] MARKER_COLOR     = 12'h0F0;

  localparam int unsigned MARKER_SIZE  = 12;
  localparam int unsigned MARKER_X_OFS = 8;
  localparam int unsigned MARKER_Y_OFS = 12;

endpackage

// File: rtl/button_cell_hit.sv
// Combinational hit test for one button: in-box and in-marker flags for the current pixel.
module button_cell_hit
  import menu_pkg::*;
#(
  parameter int unsigned X_POS  = 240,
  parameter int unsigned WIDTH  = 154,
  parameter int unsigned HEIGHT = 52
) (
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] top_y_in,
  output logic        in_box_out,
  output logic        in_marker_out
);

  localparam logic [11:0] X_LO  = 12'(X_POS);
  localparam logic [11:0] X_HI  = 12'(X_POS + WIDTH);
  localparam logic [11:0] MX_LO = 12'(X_POS + MARKER_X_OFS);
  localparam logic [11:0] MX_HI = 12'(X_POS + MARKER_X_OFS + MARKER_SIZE);

  logic [11:0] y_hi;
  logic [11:0] my_lo;
  logic [11:0] my_hi;

  always_comb begin
    y_hi  = top_y_in + 12'(HEIGHT);
    my_lo = top_y_in + 12'(MARKER_Y_OFS);
    my_hi = my_lo + 12'(MARKER_SIZE);

    in_box_out    = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                    (vcount_in >= top_y_in) && (vcount_in < y_hi);
    in_marker_out = (hcount_in >= MX_LO) && (hcount_in < MX_HI) &&
                    (vcount_in >= my_lo) && (vcount_in < my_hi);
  end

endmodule

// File: rtl/menu_button_bank.sv
// Menu button column: selection FSM, confirm flash, command strobe and registered RGB444 pixel.
// Optional BUTTON_BLINK_EN: blink the selection marker in NAV using frame_cnt[4].
module menu_button_bank
  import menu_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS  = 3,
  parameter int unsigned X_POS        = 240,
  parameter int unsigned Y_POS        = 240,
  parameter int unsigned WIDTH        = 154,
  parameter int unsigned HEIGHT       = 52,
  parameter int unsigned SPACING      = 64,
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic        up_in,
  input  logic        down_in,
  input  logic        confirm_in,
  input  logic        enable_in,
  output logic [2:0]  sel_idx_out,
  output logic        cmd_valid_out,
  output logic [11:0] pixel_out
);

  localparam logic [2:0]  LAST_IDX   = 3'(NUM_BUTTONS - 1);
  localparam int unsigned FCW        = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_FRAMES - 1);

  menu_state_t    state_q, state_d;
  logic [2:0]     sel_q, sel_d;
  logic           cmd_q, cmd_d;
  logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
  logic [4:0]     frame_cnt_q, frame_cnt_d;
  logic [11:0]    pixel_q, pixel_d;

  logic [11:0]            h12;
  logic [11:0]            v12;
  logic [NUM_BUTTONS-1:0] box_hit;
  logic [NUM_BUTTONS-1:0] mark_hit;
  logic                   any_hit;
  logic [2:0]             hit_idx;
  logic                   hit_mark;
  logic                   sel_on;
  logic                   marker_on;

  assign h12 = {1'b0, hcount_in};
  assign v12 = {2'b0, vcount_in};

  for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_cell
    localparam logic [11:0] TOP_Y = 12'(Y_POS + k * SPACING);
    button_cell_hit #(
      .X_POS (X_POS),
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
    ) u_cell (
      .hcount_in    (h12),
      .vcount_in    (v12),
      .top_y_in     (TOP_Y),
      .in_box_out   (box_hit[k]),
      .in_marker_out(mark_hit[k])
    );
  end

  // Descending scan so the lowest-numbered hit wins if boxes ever overlap.
  always_comb begin
    any_hit  = 1'b0;
    hit_idx  = '0;
    hit_mark = 1'b0;
    for (int unsigned i = NUM_BUTTONS; i > 0; i--) begin
      if (box_hit[i-1]) begin
        any_hit  = 1'b1;
        hit_idx  = 3'(i - 1);
        hit_mark = mark_hit[i-1];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cmd_d       = 1'b0;
    flash_cnt_d = flash_cnt_q;
    frame_cnt_d = new_frame_in ? frame_cnt_q + 5'd1 : frame_cnt_q;

    if (!enable_in) begin
      state_d     = IDLE;
      flash_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = NAV;
        NAV: begin
          if (confirm_in) begin
            state_d     = FLASH;
            flash_cnt_d = '0;
          end else if (up_in && !down_in) begin
            sel_d = (sel_q == '0) ? LAST_IDX : sel_q - 3'd1;
          end else if (down_in && !up_in) begin
            sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + 3'd1;
          end
        end
        FLASH: begin
          if (new_frame_in) begin
            if (flash_cnt_q == FLASH_LAST) begin
              state_d     = DONE;
              cmd_d       = 1'b1;
              flash_cnt_d = '0;
            end else begin
              flash_cnt_d = flash_cnt_q + FCW'(1);
            end
          end
        end
        DONE:    state_d = NAV;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pixel_d   = '0;
    sel_on    = 1'b1;
    marker_on = 1'b0;
    if (enable_in && any_hit) begin
      if (hit_idx == sel_q) begin
        sel_on    = !((state_q == FLASH) && frame_cnt_q[2]);
        marker_on = sel_on && hit_mark;
`ifdef BUTTON_BLINK_EN
        if ((state_q == NAV) && frame_cnt_q[4]) marker_on = 1'b0;
`endif
        pixel_d = marker_on ? MARKER_COLOR : (sel_on ? SELECTED_COLOR : DESELECTED_COLOR);
      end else begin
        pixel_d = DESELECTED_COLOR;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cmd_q       <= 1'b0;
      flash_cnt_q <= '0;
      frame_cnt_q <= '0;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cmd_q       <= cmd_d;
      flash_cnt_q <= flash_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pixel_q     <= pixel_d;
    end
  end

  assign sel_idx_out   = sel_q;
  assign cmd_valid_out = cmd_q;
  assign pixel_out     = pixel_q;

endmodule

// File: tb/tb_menu_button_bank.sv
// Scoreboard bench for menu_button_bank: rendering, navigation, flash/strobe, reset and blink.
module tb_menu_button_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        new_frame = 1'b0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        confirm = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  sel_idx;
  logic        cmd_valid;
  logic [11:0] pixel;

  typedef struct {
    logic [11:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  fc = 0;
  int  cmd_seen = 0;

  menu_button_bank #(
    .NUM_BUTTONS (3),
    .X_POS       (240),
    .Y_POS       (240),
    .WIDTH       (154),
    .HEIGHT      (52),
    .SPACING     (64),
    .FLASH_FRAMES(30)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .new_frame_in (new_frame),
    .up_in        (up),
    .down_in      (down),
    .confirm_in   (confirm),
    .enable_in    (enable),
    .sel_idx_out  (sel_idx),
    .cmd_valid_out(cmd_valid),
    .pixel_out    (pixel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cmd_valid === 1'b1) cmd_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic u, input logic d, input logic c, input logic f);
    @(negedge clk);
    up = u; down = d; confirm = c; new_frame = f;
    if (f) fc = (fc + 1) % 32;
    @(negedge clk);
    up = 1'b0; down = 1'b0; confirm = 1'b0; new_frame = 1'b0;
  endtask

  task automatic test_reset();
    sb_t e;
    enable = 1'b1;
    #1 rst_n = 1'b0;
    fc = 0;
    #11;
    sb.push_back('{12'(0), "reset_sel"});
    sb.push_back('{12'(0), "reset_cmd"});
    sb.push_back('{12'h000, "reset_pixel"});
    e = sb.pop_front(); vectors++;
    if (sel_idx !== e.exp[2:0]) begin
      miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
    end
    e = sb.pop_front(); vectors++;
    if (cmd_valid !== e.exp[0]) begin
      miscompares++; $display("FAIL %s: got %b expected %b", e.tag, cmd_valid, e.exp[0]);
    end
    e = sb.pop_front(); vectors++;
    if (pixel !== e.exp) begin
      miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_render();
    int          hs[17] = '{241, 241, 0,   250, 249, 259, 260, 393, 394, 241, 239, 240, 241, 241, 241, 2047, 241};
    int          vs[17] = '{241, 305, 0,   254, 253, 263, 263, 291, 291, 292, 241, 240, 368, 419, 420, 1023, 432};
    logic [11:0] ex[17] = '{12'hFF0, 12'hF50, 12'h000, 12'h0F0, 12'h0F0, 12'h0F0, 12'hFF0, 12'hFF0,
                            12'h000, 12'h000, 12'h000, 12'hFF0, 12'hF50, 12'hF50, 12'h000, 12'h000, 12'h000};
    sb_t e;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front(); vectors++;
        if (pixel !== e.exp) begin
          miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
        end
      end
      if (i < 17) begin
        hcount = 11'(hs[i]);
        vcount = 10'(vs[i]);
        sb.push_back('{ex[i], $sformatf("render(%0d,%0d)", hs[i], vs[i])});
      end
    end
  endtask

  task automatic test_nav();
    logic [2:0] exp_sel[3] = '{3'd2, 3'd0, 3'd1};
    sb_t e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      else        pulse(1'b0, 1'b1, 1'b0, 1'b0);
      sb.push_back('{12'(exp_sel[i]), $sformatf("nav_step%0d_sel", i)});
      e = sb.pop_front(); vectors++;
      if (sel_idx !== e.exp[2:0]) begin
        miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
      end
    end
    hcount = 11'd241; vcount = 10'd305;
    sb.push_back('{12'hFF0, "nav_highlight_btn1"});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (pixel !== e.exp) begin
      miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
    end
  endtask

  task automatic test_same_cycle();
    sb_t e;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back('{12'd1, "up_and_down_sel"});
    e = sb.pop_front(); vectors++;
    if (sel_idx !== e.exp[2:0]) begin
      miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
    end
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    sb.push_back('{12'd1, "confirm_down_sel"});
    sb.push_back('{12'd0, "confirm_down_cmd"});
    e = sb.pop_front(); vectors++;
    if (sel_idx !== e.exp[2:0]) begin
      miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
    end
    e = sb.pop_front(); vectors++;
    if (cmd_valid !== e.exp[0]) begin
      miscompares++; $display("FAIL %s: got %b expected %b", e.tag, cmd_valid, e.exp[0]);
    end
  endtask

  task automatic test_flash();
    int  seen0;
    sb_t e;
    seen0 = cmd_seen;
    for (int k = 1; k <= 30; k++) begin
      if (k % 7 == 3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 15)    pulse(1'b0, 1'b1, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      sb.push_back('{12'(k == 30), $sformatf("flash_frame%0d_cmd", k)});
      e = sb.pop_front(); vectors++;
      if (cmd_valid !== e.exp[0]) begin
        miscompares++; $display("FAIL %s: got %b expected %b", e.tag, cmd_valid, e.exp[0]);
      end
      if (k == 30) begin
        sb.push_back('{12'd1, "flash_cmd_sel"});
        e = sb.pop_front(); vectors++;
        if (sel_idx !== e.exp[2:0]) begin
          miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
        end
      end else begin
        sb.push_back('{((fc / 4) % 2 == 1) ? 12'hF50 : 12'hFF0, $sformatf("flash_frame%0d_pixel", k)});
        @(negedge clk);
        e = sb.pop_front(); vectors++;
        if (pixel !== e.exp) begin
          miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
        end
      end
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (cmd_seen - seen0 !== 1) begin
      miscompares++; $display("FAIL flash_cmd_count: got %0d expected 1", cmd_seen - seen0);
    end
  endtask

  task automatic test_reset_flash();
    int  seen0;
    sb_t e;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    seen0 = cmd_seen;
    @(negedge clk);
    #2 rst_n = 1'b0;
    fc = 0;
    #1;
    sb.push_back('{12'd0, "rst_flash_sel"});
    sb.push_back('{12'd0, "rst_flash_cmd"});
    sb.push_back('{12'h000, "rst_flash_pixel"});
    e = sb.pop_front(); vectors++;
    if (sel_idx !== e.exp[2:0]) begin
      miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
    end
    e = sb.pop_front(); vectors++;
    if (cmd_valid !== e.exp[0]) begin
      miscompares++; $display("FAIL %s: got %b expected %b", e.tag, cmd_valid, e.exp[0]);
    end
    e = sb.pop_front(); vectors++;
    if (pixel !== e.exp) begin
      miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_seen !== seen0) begin
      miscompares++; $display("FAIL rst_flash_no_cmd: got %0d strobes expected 0", cmd_seen - seen0);
    end
  endtask

  task automatic test_blink();
    logic [11:0] exp;
    sb_t e;
    hcount = 11'd250; vcount = 10'd254;
    for (int i = 0; i < 32; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BUTTON_BLINK_EN
      exp = (fc < 16) ? 12'h0F0 : 12'hFF0;
`else
      exp = 12'h0F0;
`endif
      sb.push_back('{exp, $sformatf("marker_frame%0d", fc)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (pixel !== e.exp) begin
        miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
      end
    end
  endtask

  task automatic test_disable();
    int  seen0;
    sb_t e;
    seen0 = cmd_seen;
    @(negedge clk);
    enable = 1'b0;
    hcount = 11'd241; vcount = 10'd241;
    sb.push_back('{12'h000, "disabled_pixel"});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (pixel !== e.exp) begin
      miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    repeat (31) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back('{12'd0, "disabled_sel_kept"});
    sb.push_back('{12'hFF0, "reenabled_pixel"});
    e = sb.pop_front(); vectors++;
    if (sel_idx !== e.exp[2:0]) begin
      miscompares++; $display("FAIL %s: got %0d expected %0d", e.tag, sel_idx, e.exp[2:0]);
    end
    e = sb.pop_front(); vectors++;
    if (pixel !== e.exp) begin
      miscompares++; $display("FAIL %s: got %h expected %h", e.tag, pixel, e.exp);
    end
    vectors++;
    if (cmd_seen !== seen0) begin
      miscompares++; $display("FAIL disabled_no_cmd: got %0d strobes expected 0", cmd_seen - seen0);
    end
  endtask

  initial begin
    test_reset();
    test_render();
    test_nav();
    test_same_cycle();
    test_flash();
    test_reset_flash();
    test_blink();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
